// File: rtl/fpnew_pkg_snax.sv
`default_nettype none
// ============================================================================
//  Module     : fpnew_pkg_snax (package)
//  Description: Shared FP format helpers, operand classification record,
//               IEEE status flags, special-result kinds and canonical NaN.
//  Revision   : 1.0 - initial release
// ============================================================================
package fpnew_pkg_snax;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef enum logic [1:0] {
        SPC_NONE     = 2'd0,
        SPC_QNAN     = 2'd1,
        SPC_INF_PROD = 2'd2,
        SPC_INF_ADD  = 2'd3
    } fp_special_e;

    // Positive quiet NaN: exponent all ones plus the mantissa MSB, rest zero.
    // Returned in a 64-bit container; callers keep the low fp_width bits.
    function automatic logic [63:0] canonical_nan(fp_format_e fmt);
        logic [63:0] res;
        int          lo;
        int          hi;
        res = '0;
        lo  = int'(man_bits(fmt)) - 1;
        hi  = int'(man_bits(fmt) + exp_bits(fmt));
        for (int i = 0; i < 64; i++) begin
            if (i >= lo && i < hi) res[i] = 1'b1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_pipe_stage_snax.sv
`default_nettype none
// ============================================================================
//  Module     : fpnew_pipe_stage_snax
//  Description: One valid/ready register slice with flush. Only the valid bit
//               is reset; the payload loads on an accepted handshake.
//  Ports      : clk_i, rst_i (sync, active high), flush_i,
//               in_valid_i/in_ready_o/in_data_i, out_valid_o/out_ready_i/out_data_o
//  Revision   : 1.0 - initial release
// ============================================================================
module fpnew_pipe_stage_snax #(
    parameter type DataT = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  DataT in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output DataT out_data_o
);

    logic valid_q;
    logic valid_d;
    DataT data_q;

    // Slot can take a new op when empty or when its current op leaves now.
    assign in_ready_o = ~valid_q | out_ready_i;

    always_comb begin
        valid_d = valid_q;
        if (in_ready_o) valid_d = in_valid_i;
        if (flush_i)    valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) valid_q <= 1'b0;
        else       valid_q <= valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o && !flush_i) data_q <= in_data_i;
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/fpnew_fma_special_case_snax.sv
`default_nettype none
// ============================================================================
//  Module     : fpnew_fma_special_case_snax
//  Description: Special-case (NaN/Inf) resolution for a fused a*b+c op. Builds
//               the override result and NV flag from the operand classes and
//               carries it through NumPipeRegs valid/ready stages.
//  Ports      : clk_i, rst_i, operands_i {c,b,a}, info_i, neg_prod_i,
//               neg_addend_i, tag_i, in_valid_i/in_ready_o, flush_i,
//               result_o, is_special_o, status_o, tag_o,
//               out_valid_o/out_ready_i, busy_o
//               [FPNEW_SPECIAL_CNT_EN] nan_cnt_o, nv_cnt_o
//  Config     : define FPNEW_SPECIAL_CNT_EN to add saturating output counters
//               of canonical-NaN results and NV-flagged results.
//  Revision   : 1.0 - initial release
// ============================================================================
module fpnew_fma_special_case_snax
    import fpnew_pkg_snax::*;
#(
    parameter fp_format_e  FpFormat    = fp_format_e'(0),
    parameter int unsigned NumPipeRegs = 1,
    parameter type         TagType     = logic
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [2:0][fp_width(FpFormat)-1:0]    operands_i,
    input  fp_info_t [2:0]                        info_i,
    input  logic                                  neg_prod_i,
    input  logic                                  neg_addend_i,
    input  TagType                                tag_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic                                  flush_i,
    output logic [fp_width(FpFormat)-1:0]         result_o,
    output logic                                  is_special_o,
    output status_t                               status_o,
    output TagType                                tag_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic                                  busy_o
`ifdef FPNEW_SPECIAL_CNT_EN
    ,
    output logic [31:0]                           nan_cnt_o,
    output logic [31:0]                           nv_cnt_o
`endif
);

    localparam int unsigned WIDTH    = fp_width(FpFormat);
    localparam int unsigned EXP_BITS = exp_bits(FpFormat);
    localparam int unsigned MAN_BITS = man_bits(FpFormat);

    localparam logic [63:0]      CANON_NAN_FULL = canonical_nan(FpFormat);
    localparam logic [WIDTH-1:0] CANON_NAN      = CANON_NAN_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] INF_MAG        = {1'b0, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             is_special;
        status_t          status;
        TagType           tag;
    } stage_t;

    // ------------------------------------------------------------------
    // Special-case decision
    // ------------------------------------------------------------------
    logic        w_sp;
    logic        w_sc;
    logic        w_any_sig;
    logic        w_any_nan;
    logic        w_inv_prod;
    logic        w_prod_inf;
    fp_special_e w_kind;
    logic        w_nv;
    stage_t      w_in_data;

    assign w_sp       = operands_i[0][WIDTH-1] ^ operands_i[1][WIDTH-1] ^ neg_prod_i;
    assign w_sc       = operands_i[2][WIDTH-1] ^ neg_addend_i;
    assign w_any_sig  = info_i[0].is_signalling | info_i[1].is_signalling | info_i[2].is_signalling;
    // A value that is not properly NaN-boxed reads as a quiet NaN.
    assign w_any_nan  = info_i[0].is_nan | info_i[1].is_nan | info_i[2].is_nan
                      | ~info_i[0].is_boxed | ~info_i[1].is_boxed | ~info_i[2].is_boxed;
    assign w_inv_prod = (info_i[0].is_inf & info_i[1].is_zero)
                      | (info_i[0].is_zero & info_i[1].is_inf);
    assign w_prod_inf = info_i[0].is_inf | info_i[1].is_inf;

    always_comb begin
        w_kind = SPC_NONE;
        w_nv   = 1'b0;
        if (w_any_sig) begin
            w_kind = SPC_QNAN;
            w_nv   = 1'b1;
        end else if (w_inv_prod) begin
            w_kind = SPC_QNAN;
            w_nv   = 1'b1;
        end else if (w_any_nan) begin
            w_kind = SPC_QNAN;
        end else if (w_prod_inf && info_i[2].is_inf && (w_sp != w_sc)) begin
            // inf - inf
            w_kind = SPC_QNAN;
            w_nv   = 1'b1;
        end else if (w_prod_inf) begin
            w_kind = SPC_INF_PROD;
        end else if (info_i[2].is_inf) begin
            w_kind = SPC_INF_ADD;
        end
    end

    always_comb begin
        w_in_data            = '0;
        w_in_data.tag        = tag_i;
        w_in_data.status.NV  = w_nv;
        w_in_data.is_special = (w_kind != SPC_NONE);
        case (w_kind)
            SPC_QNAN:     w_in_data.result = CANON_NAN;
            SPC_INF_PROD: w_in_data.result = INF_MAG | ({{(WIDTH-1){1'b0}}, w_sp} << (WIDTH-1));
            SPC_INF_ADD:  w_in_data.result = INF_MAG | ({{(WIDTH-1){1'b0}}, w_sc} << (WIDTH-1));
            default:      w_in_data.result = '0;
        endcase
    end

    // Only the sign bits and classes matter; magnitudes are intentionally ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^{operands_i[0][WIDTH-2:0], operands_i[1][WIDTH-2:0],
                             operands_i[2][WIDTH-2:0], info_i};

    // ------------------------------------------------------------------
    // Pipeline: node 0 is the input, node NumPipeRegs the output
    // ------------------------------------------------------------------
    stage_t                 w_node_data  [NumPipeRegs+1];
    logic [NumPipeRegs:0]   w_node_valid;
    logic [NumPipeRegs:0]   w_node_ready;

    assign w_node_data[0]            = w_in_data;
    assign w_node_valid[0]           = in_valid_i;
    assign in_ready_o                = w_node_ready[0];
    assign w_node_ready[NumPipeRegs] = out_ready_i;

    for (genvar i = 0; i < NumPipeRegs; i++) begin : g_pipe
        fpnew_pipe_stage_snax #(
            .DataT (stage_t)
        ) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .in_valid_i  (w_node_valid[i]),
            .in_ready_o  (w_node_ready[i]),
            .in_data_i   (w_node_data[i]),
            .out_valid_o (w_node_valid[i+1]),
            .out_ready_i (w_node_ready[i+1]),
            .out_data_o  (w_node_data[i+1])
        );
    end

    if (NumPipeRegs == 0) begin : g_busy_comb
        assign busy_o = 1'b0;
    end else begin : g_busy_regs
        assign busy_o = |w_node_valid[NumPipeRegs:1];
    end

    assign out_valid_o  = w_node_valid[NumPipeRegs];
    assign result_o     = w_node_data[NumPipeRegs].result;
    assign is_special_o = w_node_data[NumPipeRegs].is_special;
    assign status_o     = w_node_data[NumPipeRegs].status;
    assign tag_o        = w_node_data[NumPipeRegs].tag;

`ifdef FPNEW_SPECIAL_CNT_EN
    logic [31:0] nan_cnt_q, nan_cnt_d;
    logic [31:0] nv_cnt_q,  nv_cnt_d;
    logic        w_out_hs;

    assign w_out_hs = out_valid_o & out_ready_i;

    always_comb begin
        nan_cnt_d = nan_cnt_q;
        nv_cnt_d  = nv_cnt_q;
        if (w_out_hs && is_special_o && (result_o == CANON_NAN) && (nan_cnt_q != 32'hFFFF_FFFF))
            nan_cnt_d = nan_cnt_q + 32'd1;
        if (w_out_hs && status_o.NV && (nv_cnt_q != 32'hFFFF_FFFF))
            nv_cnt_d = nv_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nan_cnt_q <= '0;
            nv_cnt_q  <= '0;
        end else begin
            nan_cnt_q <= nan_cnt_d;
            nv_cnt_q  <= nv_cnt_d;
        end
    end

    assign nan_cnt_o = nan_cnt_q;
    assign nv_cnt_o  = nv_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpnew_fma_special_case_snax.sv
`default_nettype none
// ============================================================================
//  Module     : tb_fpnew_fma_special_case_snax
//  Description: Self-checking bench for the FMA special-case block, FP32 with
//               two pipeline stages. Expected results come from an IEEE-level
//               model over raw operand bits, matched through a scoreboard.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_fpnew_fma_special_case_snax;
    import fpnew_pkg_snax::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0][31:0]  ops;
    fp_info_t [2:0]    info;
    logic              neg_prod, neg_addend;
    logic [7:0]        tag;
    logic              in_valid, in_ready, flush;
    logic [31:0]       result;
    logic              is_special;
    status_t           status;
    logic [7:0]        tag_out;
    logic              out_valid, out_ready, busy;
`ifdef FPNEW_SPECIAL_CNT_EN
    logic [31:0]       nan_cnt, nv_cnt;
    int                nan_cnt_m = 0;
    int                nv_cnt_m  = 0;
`endif

    int errors = 0;
    int checks = 0;
    logic last_acc;

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic        sp;
        logic [7:0]  tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fpnew_fma_special_case_snax #(
        .FpFormat    (FP32),
        .NumPipeRegs (2),
        .TagType     (logic [7:0])
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .operands_i   (ops),
        .info_i       (info),
        .neg_prod_i   (neg_prod),
        .neg_addend_i (neg_addend),
        .tag_i        (tag),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .flush_i      (flush),
        .result_o     (result),
        .is_special_o (is_special),
        .status_o     (status),
        .tag_o        (tag_out),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy)
`ifdef FPNEW_SPECIAL_CNT_EN
        ,
        .nan_cnt_o    (nan_cnt),
        .nv_cnt_o     (nv_cnt)
`endif
    );

    // ---------------- reference model (IEEE view of raw bits) ----------------
    function automatic logic f_inf(logic [31:0] x);  return (x[30:23] == 8'hFF) && (x[22:0] == 0); endfunction
    function automatic logic f_nan(logic [31:0] x);  return (x[30:23] == 8'hFF) && (x[22:0] != 0); endfunction
    function automatic logic f_snan(logic [31:0] x); return f_nan(x) && !x[22]; endfunction
    function automatic logic f_zero(logic [31:0] x); return x[30:0] == 0; endfunction

    function automatic fp_info_t classify(logic [31:0] x);
        fp_info_t i;
        i = '0;
        i.is_boxed      = 1'b1;
        i.is_zero       = f_zero(x);
        i.is_subnormal  = (x[30:23] == 0) && (x[22:0] != 0);
        i.is_normal     = (x[30:23] != 0) && (x[30:23] != 8'hFF);
        i.is_inf        = f_inf(x);
        i.is_nan        = f_nan(x);
        i.is_signalling = f_snan(x);
        i.is_quiet      = f_nan(x) && x[22];
        return i;
    endfunction

    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                   logic np, logic na, logic [7:0] t);
        exp_t e;
        logic sp, sc;
        sp = a[31] ^ b[31] ^ np;
        sc = c[31] ^ na;
        e.tag = t; e.sp = 1'b1; e.nv = 1'b0; e.res = 32'h7FC0_0000;
        if (f_snan(a) || f_snan(b) || f_snan(c))                          e.nv = 1'b1;
        else if ((f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b)))      e.nv = 1'b1;
        else if (f_nan(a) || f_nan(b) || f_nan(c))                        e.nv = 1'b0;
        else if ((f_inf(a) || f_inf(b)) && f_inf(c) && (sp != sc))        e.nv = 1'b1;
        else if (f_inf(a) || f_inf(b))                                    e.res = sp ? 32'hFF80_0000 : 32'h7F80_0000;
        else if (f_inf(c))                                                e.res = sc ? 32'hFF80_0000 : 32'h7F80_0000;
        else begin e.sp = 1'b0; e.res = 32'h0; end
        return e;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return 32'h7FC0_0001;
            5: return 32'h7F80_0001;
            6: return 32'h3F80_0000;
            default: return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    task automatic set_op(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                          logic np, logic na, logic [7:0] t);
        ops[0] = a; ops[1] = b; ops[2] = c;
        info[0] = classify(a); info[1] = classify(b); info[2] = classify(c);
        neg_prod = np; neg_addend = na; tag = t;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step();
        logic ret;
        exp_t e;
        #1;
        ret      = out_valid & out_ready;
        last_acc = in_valid & in_ready & !flush;
        if (ret === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result=%h tag=%h, required no output", result, tag_out);
            end else begin
                e = sb.pop_front();
                if ({result, status, is_special, tag_out} !== {e.res, e.nv, 4'b0, e.sp, e.tag}) begin
                    errors++;
                    $display("FAIL output: got res=%h st=%b sp=%b tag=%h, required res=%h st=%b sp=%b tag=%h",
                             result, status, is_special, tag_out, e.res, {e.nv, 4'b0}, e.sp, e.tag);
                end
`ifdef FPNEW_SPECIAL_CNT_EN
                if (e.sp && e.res == 32'h7FC0_0000) nan_cnt_m++;
                if (e.nv) nv_cnt_m++;
`endif
            end
        end
        if (flush) sb.delete();
        if (last_acc) sb.push_back(model(ops[0], ops[1], ops[2], neg_prod, neg_addend, tag));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d ops pending, required 0", sb.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        set_op(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset: got valid/busy/ready=%b, required 001", {out_valid, busy, in_ready});
        end
    endtask

    // Single op with a free output: appears exactly two cycles after accept.
    task automatic send_single(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                               logic np, logic na, logic [7:0] t);
        set_op(a, b, c, np, na, t);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got out_valid=%b two cycles after accept, required 1", out_valid);
        end
        step();
    endtask

    task automatic test_directed();
        send_single(32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 0, 0, 8'h11);
        send_single(32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 0, 0, 8'h22);
        send_single(32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 0, 1, 8'h33);
        send_single(32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 0, 0, 8'h44);
        send_single(32'h7FC0_0001, 32'h3F80_0000, 32'h3F80_0000, 0, 0, 8'h55);
        send_single(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 8'hA5);
        send_single(32'h3F80_0000, 32'hFF80_0000, 32'h4040_0000, 1, 0, 8'h66);
        send_single(32'h3F80_0000, 32'h4000_0000, 32'h7F80_0000, 0, 1, 8'h77);
        drain();
    endtask

    task automatic test_stall();
        int n_acc;
        n_acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op(rand_val(), rand_val(), rand_val(), 0, 0, 8'(8'hC0 + n_acc));
            in_valid = (n_acc < 4);
            step();
            if (last_acc) n_acc++;
        end
        checks++;
        if (n_acc != 2 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall: got accepted=%0d in_ready=%b busy=%b, required 2 0 1", n_acc, in_ready, busy);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && n_acc < 4; i++) begin
            set_op(rand_val(), rand_val(), rand_val(), 0, 0, 8'(8'hC0 + n_acc));
            in_valid = 1'b1;
            step();
            if (last_acc) n_acc++;
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc)
                set_op(rand_val(), rand_val(), rand_val(), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 8'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_op(32'h7F80_0001, 32'h3F80_0000, 32'h0, 0, 0, 8'(8'hF0 + i));
            in_valid = 1'b1;
            step();
        end
        set_op(32'h7F80_0000, 32'h0, 32'h0, 0, 0, 8'hFF);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush: got out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        out_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got busy=%b after flush, required 0", busy);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; last_acc = 1'b0;
        set_op(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_flush();
`ifdef FPNEW_SPECIAL_CNT_EN
        checks++;
        if (nan_cnt !== 32'(nan_cnt_m) || nv_cnt !== 32'(nv_cnt_m)) begin
            errors++;
            $display("FAIL counters: got nan=%0d nv=%0d, required nan=%0d nv=%0d", nan_cnt, nv_cnt, nan_cnt_m, nv_cnt_m);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
